// File: rtl/pudding_dac_loader_if.sv
// ---------------------------------------------------------------------------
// pudding_dac_loader_if
//
// Bundle between a code requester, the PUDDING DAC loader and the DAC
// daisy-chain/state registers.
//
//   Request side (requester -> loader):
//     code, code_valid, clk_div, abort
//   Request side (loader -> requester):
//     code_ready, busy, done, clamped, applied_code
//   Chain side (loader -> DAC chain):
//     datum, shift, transfer, dir
//
// Modports:
//   master  : the requester (drives the request, observes everything else)
//   slave   : the loader itself
//   chain   : the DAC chain registers (observe the serial strobes only)
// ---------------------------------------------------------------------------
interface pudding_dac_loader_if #(
  parameter int CODE_W = 8,
  parameter int DIV_W  = 8
);

  // request handshake
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              code_ready;
  logic [DIV_W-1:0]  clk_div;
  logic              abort;

  // serial load strobes towards the DAC chain
  logic              datum;
  logic              shift;
  logic              transfer;
  logic              dir;

  // status
  logic              busy;
  logic              done;
  logic              clamped;
  logic [CODE_W-1:0] applied_code;

  modport master (
    output code,
    output code_valid,
    output clk_div,
    output abort,
    input  code_ready,
    input  datum,
    input  shift,
    input  transfer,
    input  dir,
    input  busy,
    input  done,
    input  clamped,
    input  applied_code
  );

  modport slave (
    input  code,
    input  code_valid,
    input  clk_div,
    input  abort,
    output code_ready,
    output datum,
    output shift,
    output transfer,
    output dir,
    output busy,
    output done,
    output clamped,
    output applied_code
  );

  modport chain (
    input datum,
    input shift,
    input transfer,
    input dir
  );

endinterface

// File: rtl/pudding_dac_loader.sv
// ---------------------------------------------------------------------------
// pudding_dac_loader
//
// Turns an 8-bit "number of active cells" request into the serial load
// protocol of the PUDDING current-steering DAC: a CHAIN_LEN-bit thermometer
// pattern is shifted into the daisy chain (one bit per clk_div+1 cycles),
// then committed to the cell state with a single chain->state transfer.
//
// Ports:
//   clk    : single clock, shared with the DAC chain registers
//   rst_n  : asynchronous active-low reset
//   bus    : pudding_dac_loader_if.slave
//            code/code_valid/code_ready : request handshake
//            clk_div                    : bit period minus one (sampled at accept)
//            abort                      : cancel a load while shifting
//            datum/shift/transfer/dir   : DAC chain strobes
//            busy/done/clamped/applied_code : status
//
// Sequence after the accept edge (cycle 0):
//   cycles 1 .. CHAIN_LEN*(clk_div+1)   : SHIFT, shift pulses on the first
//                                          cycle of each bit period
//   cycle  1 + CHAIN_LEN*(clk_div+1)    : XFER  (transfer=dir=1)
//   next cycle                          : DONE  (done=1, applied_code updated)
//   next cycle                          : IDLE  (code_ready=1)
// ---------------------------------------------------------------------------
module pudding_dac_loader #(
  parameter int CHAIN_LEN = 128,
  parameter int CODE_W    = 8,
  parameter int DIV_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pudding_dac_loader_if.slave   bus
);

  // Bit index spans 0..CHAIN_LEN-1.
  localparam int IDX_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  localparam logic [CODE_W-1:0] FULL_CODE = CODE_W'(CHAIN_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_XFER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t            state_q,    state_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;       // bit currently on datum
  logic [DIV_W-1:0]  cnt_q,      cnt_d;       // position inside bit period
  logic [DIV_W-1:0]  div_q,      div_d;       // captured clk_div
  logic [CODE_W-1:0] code_eff_q, code_eff_d;  // clamped code of this load
  logic              clamped_q,  clamped_d;
  logic [CODE_W-1:0] applied_q,  applied_d;

  logic              accept;
  logic              period_end;
  logic [CODE_W-1:0] cell_pos;

  // Request accepted only in IDLE; code_valid while busy simply waits.
  assign accept = bus.code_valid && (state_q == S_IDLE);

  // Last cycle of the current bit period. The counter wraps at the
  // captured divider, independent of the chain length.
  assign period_end = (cnt_q == div_q);

  // Bit k ends up in cell CHAIN_LEN-1-k once all CHAIN_LEN bits are shifted,
  // so that is the cell whose on/off value datum must carry now.
  assign cell_pos = FULL_CODE - CODE_W'(1) - CODE_W'(idx_q);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      code_eff_q <= '0;
      clamped_q  <= 1'b0;
      applied_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      code_eff_q <= code_eff_d;
      clamped_q  <= clamped_d;
      applied_q  <= applied_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    code_eff_d = code_eff_q;
    clamped_d  = clamped_q;
    applied_d  = applied_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Clamp flag reflects only the most recently accepted request.
          if (bus.code > FULL_CODE) begin
            code_eff_d = FULL_CODE;
            clamped_d  = 1'b1;
          end else begin
            code_eff_d = bus.code;
            clamped_d  = 1'b0;
          end
          div_d   = bus.clk_div;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (bus.abort) begin
          // Partial chain content is left behind; the next load rewrites
          // every cell, so nothing needs to be undone here.
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (period_end) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_XFER;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      // Commit cycle; abort is deliberately not looked at from here on.
      S_XFER: begin
        state_d = S_DONE;
      end

      S_DONE: begin
        applied_d = code_eff_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs (decoded from registered state, so they follow an asynchronous
  // reset without waiting for a clock edge)
  // -------------------------------------------------------------------------
  assign bus.code_ready   = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);

  // datum is held for the whole bit period, including its shift cycle.
  assign bus.datum        = (state_q == S_SHIFT) && (cell_pos < code_eff_q);
  assign bus.shift        = (state_q == S_SHIFT) && (cnt_q == '0);

  // Only chain->state transfers are ever issued, so dir mirrors transfer.
  assign bus.transfer     = (state_q == S_XFER);
  assign bus.dir          = (state_q == S_XFER);

  assign bus.done         = (state_q == S_DONE);
  assign bus.clamped      = clamped_q;
  assign bus.applied_code = applied_q;

endmodule

// File: tb/tb_pudding_dac_loader.sv
// ---------------------------------------------------------------------------
// tb_pudding_dac_loader
//
// Directed bench for pudding_dac_loader with a behavioural model of the
// 128-cell DAC daisy chain and state register attached to the strobes.
// ---------------------------------------------------------------------------
module tb_pudding_dac_loader;

  logic clk;
  logic rst_n;

  pudding_dac_loader_if #(.CODE_W(8), .DIV_W(8)) bus ();

  pudding_dac_loader #(
    .CHAIN_LEN (128),
    .CODE_W    (8),
    .DIV_W     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DAC chain model: first bit shifted lands in cell 127 after 128 shifts.
  // ---------------------------------------------------------------------------
  logic [127:0] chain_m;
  logic [127:0] state_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_m <= '0;
      state_m <= '0;
    end else begin
      if (bus.shift)
        chain_m <= {chain_m[126:0], bus.datum};
      if (bus.transfer && bus.dir)
        state_m <= chain_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mask_n(input int n);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 128; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  // Per-load observations, cycle numbers counted from the accept edge.
  int n_shift, first_shift, last_shift;
  int xfer_cnt, xfer_cyc, done_cnt, done_cyc, ready_cyc, abort_cyc;
  int datum_err, pos_err, stab_err, viol;

  // Drive one request (caller is at a negedge) and watch it to completion.
  // abort_bit >= 0 raises abort during that bit's shift cycle.
  // hold=1 keeps code_valid high with hold_code after the accept.
  task automatic do_load(input int c, input int div, input int abort_bit,
                         input bit hold, input int hold_code);
    bit   accepted;
    bit   prev_d;
    bit   exp_d;
    int   ceff;
    int   budget;
    n_shift = 0; first_shift = 0; last_shift = 0;
    xfer_cnt = 0; xfer_cyc = 0; done_cnt = 0; done_cyc = 0;
    ready_cyc = 0; abort_cyc = 0;
    datum_err = 0; pos_err = 0; stab_err = 0; viol = 0;
    prev_d = 1'b0;
    ceff   = (c > 128) ? 128 : c;
    budget = 1 + 128 * (div + 1) + 8;

    bus.code       = c[7:0];
    bus.clk_div    = div[7:0];
    bus.code_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 4000 && !accepted; i++) begin
      if (bus.code_ready === 1'b1) begin
        @(posedge clk);
        accepted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!accepted) begin
      check("accept_timeout", 0, 1);
      bus.code_valid = 1'b0;
      return;
    end
    #1;
    if (hold) bus.code = hold_code[7:0];
    else      bus.code_valid = 1'b0;
    // Changing the divider after the accept must not matter.
    bus.clk_div = ~div[7:0];

    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (bus.shift) begin
        if (cyc != 1 + n_shift * (div + 1)) pos_err++;
        exp_d = ((127 - n_shift) < ceff);
        if (bus.datum !== exp_d) datum_err++;
        if (n_shift == 0) first_shift = cyc;
        last_shift = cyc;
        n_shift++;
        if (abort_bit >= 0 && n_shift - 1 == abort_bit) begin
          bus.abort = 1'b1;
          abort_cyc = cyc;
        end
      end else if (bus.busy && !bus.transfer && !bus.done && bus.datum !== prev_d) begin
        stab_err++;
      end
      prev_d = bus.datum;
      if (bus.shift && bus.transfer) viol++;
      if (bus.dir && !bus.transfer)  viol++;
      if (bus.transfer) begin xfer_cnt++; xfer_cyc = cyc; end
      if (bus.done)     begin done_cnt++; done_cyc = cyc; end
      if (bus.code_ready) begin
        ready_cyc = cyc;
        bus.abort = 1'b0;
        break;
      end
    end
    bus.abort = 1'b0;
    if (ready_cyc == 0) check("load_timeout", 0, 1);
    $display("load code=%0d div=%0d abort_bit=%0d: shifts=%0d first=%0d last=%0d xfer=%0d done=%0d ready=%0d applied=%0d clamped=%0b",
             c, div, abort_bit, n_shift, first_shift, last_shift, xfer_cyc, done_cyc,
             ready_cyc, bus.applied_code, bus.clamped);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n          = 1'b0;
    bus.code       = '0;
    bus.code_valid = 1'b0;
    bus.clk_div    = '0;
    bus.abort      = 1'b0;
    #23 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ready",    bus.code_ready,   1);
    check("rst_busy",     bus.busy,         0);
    check("rst_shift",    bus.shift,        0);
    check("rst_transfer", bus.transfer,     0);
    check("rst_dir",      bus.dir,          0);
    check("rst_datum",    bus.datum,        0);
    check("rst_done",     bus.done,         0);
    check("rst_clamped",  bus.clamped,      0);
    check("rst_applied",  bus.applied_code, 0);

    // Code 5, clk_div 0
    do_load(5, 0, -1, 1'b0, 0);
    check("c5_nshift",   n_shift,          128);
    check("c5_first",    first_shift,      1);
    check("c5_last",     last_shift,       128);
    check("c5_xfer",     xfer_cyc,         129);
    check("c5_xfer_cnt", xfer_cnt,         1);
    check("c5_done",     done_cyc,         130);
    check("c5_done_cnt", done_cnt,         1);
    check("c5_ready",    ready_cyc,        131);
    check("c5_datum",    datum_err,        0);
    check("c5_pos",      pos_err,          0);
    check("c5_viol",     viol,             0);
    check("c5_state",    state_m,          mask_n(5));
    check("c5_applied",  bus.applied_code, 5);
    check("c5_clamped",  bus.clamped,      0);

    // Code 200 clamps to 128
    do_load(200, 0, -1, 1'b0, 0);
    check("c200_clamped", bus.clamped,      1);
    check("c200_state",   state_m,          {128{1'b1}});
    check("c200_applied", bus.applied_code, 128);
    check("c200_datum",   datum_err,        0);

    // Code 0 after a clamp
    do_load(0, 0, -1, 1'b0, 0);
    check("c0_clamped", bus.clamped,      0);
    check("c0_state",   state_m,          128'd0);
    check("c0_applied", bus.applied_code, 0);
    check("c0_xfer",    xfer_cyc,         129);
    check("c0_nshift",  n_shift,          128);

    // clk_div 3, code 64
    do_load(64, 3, -1, 1'b0, 0);
    check("d3_nshift",  n_shift,          128);
    check("d3_pos",     pos_err,          0);
    check("d3_stable",  stab_err,         0);
    check("d3_last",    last_shift,       509);
    check("d3_xfer",    xfer_cyc,         513);
    check("d3_done",    done_cyc,         514);
    check("d3_datum",   datum_err,        0);
    check("d3_state",   state_m,          mask_n(64));
    check("d3_applied", bus.applied_code, 64);

    // Abort: load 10, then abort a load of 100 at bit 50
    do_load(10, 0, -1, 1'b0, 0);
    check("c10_applied", bus.applied_code, 10);
    do_load(100, 0, 50, 1'b0, 0);
    check("ab_xfer_cnt", xfer_cnt,         0);
    check("ab_done_cnt", done_cnt,         0);
    check("ab_abort_cyc", abort_cyc,       51);
    check("ab_ready",    ready_cyc,        52);
    check("ab_applied",  bus.applied_code, 10);
    check("ab_state",    state_m,          mask_n(10));

    // Held request: code 7 waits behind a busy load of code 3
    do_load(3, 0, -1, 1'b1, 7);
    check("hold_done_cnt", done_cnt,         1);
    check("hold_ready",    ready_cyc,        131);
    check("hold_applied3", bus.applied_code, 3);
    check("hold_state3",   state_m,          mask_n(3));
    do_load(7, 0, -1, 1'b0, 0);
    check("hold_xfer",     xfer_cyc,         129);
    check("hold_applied7", bus.applied_code, 7);
    check("hold_state7",   state_m,          mask_n(7));

    // Asynchronous reset in the middle of a load of 120
    bus.code       = 8'd120;
    bus.clk_div    = 8'd0;
    bus.code_valid = 1'b1;
    @(posedge clk);
    #1 bus.code_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("ar_pre_busy",  bus.busy,  1);
    check("ar_pre_shift", bus.shift, 1);
    check("ar_pre_datum", bus.datum, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_shift",   bus.shift,        0);
    check("ar_datum",   bus.datum,        0);
    check("ar_busy",    bus.busy,         0);
    check("ar_applied", bus.applied_code, 0);
    check("ar_state",   state_m,          128'd0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("ar_ready", bus.code_ready, 1);
    do_load(1, 0, -1, 1'b0, 0);
    check("ar_c1_xfer",    xfer_cyc,         129);
    check("ar_c1_done",    done_cyc,         130);
    check("ar_c1_state",   state_m,          mask_n(1));
    check("ar_c1_applied", bus.applied_code, 1);
    check("ar_c1_clamped", bus.clamped,      0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
